// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised 2R1W register file with bypass, zero register and clear engine
//
// Purpose: operand register file between decode and the ALU operand latches.
//   Two registered read ports (1-cycle latency), one write port, optional
//   same-cycle write-to-read bypass, optional hardwired-zero entry 0, and a
//   sweep engine that zeroes every entry after reset or on i_clear.
// Ports:
//   i_clk        clock, rising edge
//   i_rst        asynchronous reset, active-high
//   i_clear      request to zero all entries (sampled only when not busy)
//   i_wr_en      write enable
//   i_wr_addr    write address (rd)
//   i_wr_data    write data
//   i_rd_en      read enable; outputs hold when low
//   i_rd_addr_a  read address port A (rs)
//   i_rd_addr_b  read address port B (rt)
//   o_rd_data_a  registered read data port A
//   o_rd_data_b  registered read data port B
//   o_busy       high while the clear sweep runs
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr_a,
  input  logic [ADDR_W-1:0] i_rd_addr_b,
  output logic [DATA_W-1:0] o_rd_data_a,
  output logic [DATA_W-1:0] o_rd_data_b,
  output logic              o_busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W:0]   r_cnt;
  logic [ADDR_W:0]   w_cnt_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_a;
  logic [DATA_W-1:0] r_rd_b;
  logic              w_ready;
  logic              w_wr_eff;
  logic [DATA_W-1:0] w_val_a;
  logic [DATA_W-1:0] w_val_b;

  assign w_ready = (r_state == S_READY);
  assign o_busy  = ~w_ready;

  // A write only lands when the file is usable, no clear is being accepted
  // on the same edge, and it does not target a hardwired-zero entry 0.
  assign w_wr_eff = w_ready && i_wr_en && !i_clear &&
                    !((ZERO_REG != 0) && (i_wr_addr == '0));

  // Read value resolution: hardwired zero first, then bypass, then array.
  assign w_val_a = ((ZERO_REG != 0) && (i_rd_addr_a == '0)) ? '0 :
                   ((BYPASS != 0) && w_wr_eff && (i_wr_addr == i_rd_addr_a)) ? i_wr_data :
                   r_mem[i_rd_addr_a];
  assign w_val_b = ((ZERO_REG != 0) && (i_rd_addr_b == '0)) ? '0 :
                   ((BYPASS != 0) && w_wr_eff && (i_wr_addr == i_rd_addr_b)) ? i_wr_data :
                   r_mem[i_rd_addr_b];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_CLEAR: begin
        if (r_cnt == LAST) begin
          w_state_nxt = S_READY;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_READY: begin
        if (i_clear) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_CLEAR;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Array has no reset: the sweep is what defines its contents.
  always_ff @(posedge i_clk) begin
    if (!w_ready) begin
      r_mem[r_cnt[ADDR_W-1:0]] <= '0;
    end else if (w_wr_eff) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_a <= '0;
      r_rd_b <= '0;
    end else if (i_rd_en) begin
      r_rd_a <= w_ready ? w_val_a : '0;
      r_rd_b <= w_ready ? w_val_b : '0;
    end
  end

  assign o_rd_data_a = r_rd_a;
  assign o_rd_data_b = r_rd_b;

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - scoreboard bench for regfile_param (default and no-zero/no-bypass configs)
module tb_regfile_param;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] ra = '0;
  logic [AW-1:0] rb = '0;
  logic [DW-1:0] rda0, rdb0, rda1, rdb1;
  logic          busy0, busy1;

  always #5 clk = ~clk;

  regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_rd_en(rd_en), .i_rd_addr_a(ra), .i_rd_addr_b(rb),
    .o_rd_data_a(rda0), .o_rd_data_b(rdb0), .o_busy(busy0));

  regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0), .BYPASS(0)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_rd_en(rd_en), .i_rd_addr_a(ra), .i_rd_addr_b(rb),
    .o_rd_data_a(rda1), .o_rd_data_b(rdb1), .o_busy(busy1));

  typedef struct packed {
    logic [1:0]    busy;
    logic [DW-1:0] a0;
    logic [DW-1:0] b0;
    logic [DW-1:0] a1;
    logic [DW-1:0] b1;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: config 0 = zero reg + bypass, config 1 = neither.
  logic [DW-1:0] m_mem [2][DEPTH];
  logic [DW-1:0] m_a [2];
  logic [DW-1:0] m_b [2];
  int            m_left = DEPTH;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] m_val(input int k, input logic [AW-1:0] addr,
                                          input logic eff, input logic [AW-1:0] wa,
                                          input logic [DW-1:0] wd);
    if (k == 0 && addr == 0) return '0;
    if (k == 0 && eff && wa == addr) return wd;
    return m_mem[k][addr];
  endfunction

  task automatic zero_mem();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < DEPTH; i++) m_mem[k][i] = '0;
  endtask

  task automatic drive(input logic r, input logic c, input logic we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] aa,
                       input logic [AW-1:0] ab);
    exp_t e;
    logic eff;
    @(negedge clk);
    rst = r; clear = c; wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; ra = aa; rb = ab;
    if (r) begin
      m_left = DEPTH;
      zero_mem();
      for (int k = 0; k < 2; k++) begin m_a[k] = '0; m_b[k] = '0; end
      #1;
      chk("async_rst_busy", {30'd0, busy1, busy0}, 32'd3);
      chk("async_rst_data0", rda0 | rdb0, '0);
      chk("async_rst_data1", rda1 | rdb1, '0);
    end else if (m_left > 0) begin
      for (int k = 0; k < 2; k++) if (re) begin m_a[k] = '0; m_b[k] = '0; end
      m_left--;
    end else begin
      for (int k = 0; k < 2; k++) begin
        eff = we && !c && !(k == 0 && wa == 0);
        if (re) begin
          m_a[k] = m_val(k, aa, eff, wa, wd);
          m_b[k] = m_val(k, ab, eff, wa, wd);
        end
      end
      if (c) begin
        m_left = DEPTH;
        zero_mem();
      end else if (we) begin
        if (wa != 0) m_mem[0][wa] = wd;
        m_mem[1][wa] = wd;
      end
    end
    e.busy = (m_left > 0) ? 2'b11 : 2'b00;
    e.a0 = m_a[0]; e.b0 = m_b[0]; e.a1 = m_a[1]; e.b1 = m_b[1];
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, '0, '0, 0, '0, '0);
  endtask

  // Monitor: every DUT edge produces a state update; compare it after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("busy0", {31'd0, busy0}, {31'd0, e.busy[0]});
        chk("busy1", {31'd0, busy1}, {31'd0, e.busy[1]});
        chk("rd_a0", rda0, e.a0);
        chk("rd_b0", rdb0, e.b0);
        chk("rd_a1", rda1, e.a1);
        chk("rd_b1", rdb1, e.b1);
      end
    end
  end

  initial begin
    logic [AW-1:0] a;
    // Reset sweep with reads of entry 7 and ignored writes.
    drive(1, 0, 0, '0, '0, 1, 5'd7, 5'd7);
    drive(1, 0, 0, '0, '0, 1, 5'd7, 5'd7);
    for (int i = 0; i < DEPTH; i++)
      drive(0, 0, 1, 5'($urandom), $urandom, 1, 5'd7, 5'd7);
    drive(0, 0, 0, '0, '0, 1, 5'd7, 5'd7);

    // Write then read, then hold with rd_en low.
    drive(0, 0, 1, 5'd5, 32'hDEADBEEF, 0, '0, '0);
    drive(0, 0, 0, '0, '0, 1, 5'd5, 5'd5);
    drive(0, 0, 1, 5'd5, 32'h0BADF00D, 0, 5'd1, 5'd2);
    drive(0, 0, 0, '0, '0, 1, 5'd5, 5'd9);

    // Bypass on port B, both configs.
    drive(0, 0, 1, 5'd9, 32'hAAAA0000, 0, '0, '0);
    drive(0, 0, 1, 5'd9, 32'h12345678, 1, 5'd9, 5'd9);
    drive(0, 0, 0, '0, '0, 1, 5'd9, 5'd9);

    // Zero register.
    drive(0, 0, 1, 5'd0, 32'hFFFFFFFF, 0, '0, '0);
    drive(0, 0, 0, '0, '0, 1, 5'd0, 5'd0);
    drive(0, 0, 1, 5'd0, 32'h5A5A5A5A, 1, 5'd0, 5'd0);

    // Fill, then clear with a simultaneous write to r3.
    for (int i = 1; i < DEPTH; i++) drive(0, 0, 1, 5'(i), DW'(i), 0, '0, '0);
    drive(0, 0, 0, '0, '0, 1, 5'd3, 5'd31);
    drive(0, 1, 1, 5'd3, 32'hCAFE0003, 1, 5'd3, 5'd4);
    for (int i = 0; i < DEPTH; i++)
      drive(0, 0, 1, 5'($urandom), $urandom, 1, 5'($urandom), 5'd3);
    for (int i = 0; i < DEPTH; i++) drive(0, 0, 0, '0, '0, 1, 5'(i), 5'(DEPTH - 1 - i));

    // Reset at sweep cycle 10.
    for (int i = 1; i < 8; i++) drive(0, 0, 1, 5'(i), $urandom, 0, '0, '0);
    drive(0, 1, 0, '0, '0, 0, '0, '0);
    for (int i = 0; i < 10; i++) drive(0, 0, 1, 5'($urandom), $urandom, 1, 5'd2, 5'd3);
    drive(1, 0, 1, 5'd2, 32'h11111111, 1, 5'd2, 5'd3);
    for (int i = 0; i < DEPTH + 2; i++)
      drive(0, 0, 1, 5'($urandom), $urandom, 1, 5'($urandom), 5'($urandom));

    // Randomized traffic with address collisions favoured.
    for (int i = 0; i < 800; i++) begin
      logic r, c, we, re;
      logic [AW-1:0] wa, aa, ab;
      r  = ($urandom_range(0, 299) == 0);
      c  = ($urandom_range(0, 79) == 0);
      we = ($urandom_range(0, 9) < 7);
      re = ($urandom_range(0, 9) < 8);
      wa = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      aa = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      ab = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      drive(r, c, we, wa, $urandom, re, aa, ab);
    end
    idle(2);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #3;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
